// File: rtl/cvxif_vec_issue_seq.sv
// cvxif_vec_issue_seq: decodes custom vector instructions against a parameter
// table, queues accepted ops in a small FIFO, runs them one at a time for a
// per-op cycle count and returns in-order results on a valid/ready channel.
// A busy bit per vector register blocks issue of ops that touch a destination
// still owned by an earlier op.
module cvxif_vec_issue_seq #(
  parameter int                        NB_INSTR  = 4,
  parameter int                        VLEN_W    = 10,
  parameter int                        NUM_VREG  = 8,
  parameter int                        DEPTH     = 4,
  parameter int                        ID_W      = 3,
  parameter logic [NB_INSTR*32-1:0]     TBL_INSTR = '0,
  parameter logic [NB_INSTR*32-1:0]     TBL_MASK  = '0,
  parameter logic [NB_INSTR*VLEN_W-1:0] TBL_LEN   = '0,
  parameter logic [NB_INSTR-1:0]        TBL_WB    = '0
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic                        issue_valid_i,
  output logic                        issue_ready_o,
  input  logic [31:0]                 issue_instr_i,
  input  logic [ID_W-1:0]             issue_id_i,
  output logic                        issue_accept_o,
  output logic                        issue_writeback_o,
  output logic                        result_valid_o,
  input  logic                        result_ready_i,
  output logic [ID_W-1:0]             result_id_o,
  output logic                        result_we_o,
  output logic [$clog2(NB_INSTR)-1:0] result_op_o,
  output logic                        busy_o
);

  localparam int OP_W = $clog2(NB_INSTR);
  localparam int RW   = $clog2(NUM_VREG);
  localparam int AW   = $clog2(DEPTH);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    EXEC   = 2'd1,
    RESULT = 2'd2
  } state_t;

  typedef struct packed {
    logic [ID_W-1:0]   id;
    logic [OP_W-1:0]   op;
    logic [VLEN_W-1:0] len;
    logic              wb;
    logic [RW-1:0]     vd;
  } entry_t;

  // Lowest-index set bit of the hit vector; lower table entries take priority.
  function automatic logic [OP_W-1:0] first_hit(input logic [NB_INSTR-1:0] v);
    logic [OP_W-1:0] idx;
    idx = '0;
    for (int k = NB_INSTR - 1; k >= 0; k--) begin
      if (v[k]) begin
        idx = OP_W'(k);
      end
    end
    return idx;
  endfunction

  // One-hot mask for a vector register number.
  function automatic logic [NUM_VREG-1:0] vreg_bit(input logic [RW-1:0] r);
    logic [NUM_VREG-1:0] m;
    m    = '0;
    m[r] = 1'b1;
    return m;
  endfunction

  logic [NB_INSTR-1:0] hit_s;
  logic                match_s;
  logic [OP_W-1:0]     match_idx_s;
  logic [RW-1:0]       vd_s;
  logic [RW-1:0]       vs1_s;
  logic                hazard_s;
  logic                ready_s;
  logic                enq_s;
  entry_t              new_entry_s;
  entry_t              head_s;

  entry_t              mem_r [DEPTH];
  logic [AW:0]         wptr_r;
  logic [AW:0]         rptr_r;
  logic                empty_s;
  logic                full_s;

  logic [NUM_VREG-1:0] busy_r;
  logic [NUM_VREG-1:0] set_mask_s;
  logic [NUM_VREG-1:0] clr_mask_s;
  logic                res_hs_s;

  state_t              state_r;
  logic [VLEN_W-1:0]   cnt_r;
  logic [ID_W-1:0]     cur_id_r;
  logic [OP_W-1:0]     cur_op_r;
  logic                cur_wb_r;
  logic [RW-1:0]       cur_vd_r;

  logic                result_valid_r;
  logic [ID_W-1:0]     result_id_r;
  logic                result_we_r;
  logic [OP_W-1:0]     result_op_r;

  // Masked compare of the incoming word against every table entry.
  for (genvar k = 0; k < NB_INSTR; k++) begin : g_hit
    assign hit_s[k] = ((issue_instr_i ^ TBL_INSTR[32*k +: 32]) & TBL_MASK[32*k +: 32]) == 32'h0000_0000;
  end

  // Extra pointer bit distinguishes full from empty when the indices are equal.
  assign empty_s = (wptr_r == rptr_r);
  assign full_s  = (wptr_r[AW] != rptr_r[AW]) && (wptr_r[AW-1:0] == rptr_r[AW-1:0]);
  assign head_s  = mem_r[rptr_r[AW-1:0]];

  // Decode the current request: winning entry, register fields, hazard, ready.
  always_comb begin
    match_s     = |hit_s;
    match_idx_s = first_hit(hit_s);
    vd_s        = issue_instr_i[7 +: RW];
    vs1_s       = issue_instr_i[15 +: RW];
    hazard_s    = busy_r[vd_s] | busy_r[vs1_s];
    if (match_s) begin
      ready_s = !full_s && !hazard_s;
    end else begin
      ready_s = 1'b1;
    end
    enq_s           = issue_valid_i && match_s && ready_s;
    new_entry_s.id  = issue_id_i;
    new_entry_s.op  = match_idx_s;
    new_entry_s.len = TBL_LEN[int'(match_idx_s)*VLEN_W +: VLEN_W];
    new_entry_s.wb  = TBL_WB[match_idx_s];
    new_entry_s.vd  = vd_s;
  end

  assign issue_ready_o     = ready_s;
  assign issue_accept_o    = match_s;
  assign issue_writeback_o = match_s & new_entry_s.wb;

  // Store accepted ops; storage needs no reset because the pointers gate reads.
  always_ff @(posedge clk_i) begin
    if (enq_s) begin
      mem_r[wptr_r[AW-1:0]] <= new_entry_s;
    end
  end

  // Advance the write pointer on every accepted op.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wptr_r <= '0;
    end else if (enq_s) begin
      wptr_r <= wptr_r + (AW+1)'(1);
    end else begin
      wptr_r <= wptr_r;
    end
  end

  // Scoreboard set/clear masks for this cycle.
  always_comb begin
    res_hs_s = result_valid_r & result_ready_i;
    if (enq_s) begin
      set_mask_s = vreg_bit(vd_s);
    end else begin
      set_mask_s = '0;
    end
    if (res_hs_s) begin
      clr_mask_s = vreg_bit(cur_vd_r);
    end else begin
      clr_mask_s = '0;
    end
  end

  // Busy scoreboard update; a set on the same register overrides a clear.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      busy_r <= '0;
    end else begin
      busy_r <= (busy_r & ~clr_mask_s) | set_mask_s;
    end
  end

  // Sequencer: pop, count down the execution length, then hold the result.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_r        <= IDLE;
      rptr_r         <= '0;
      cnt_r          <= '0;
      cur_id_r       <= '0;
      cur_op_r       <= '0;
      cur_wb_r       <= 1'b0;
      cur_vd_r       <= '0;
      result_valid_r <= 1'b0;
      result_id_r    <= '0;
      result_we_r    <= 1'b0;
      result_op_r    <= '0;
    end else begin
      case (state_r)
        IDLE: begin
          if (!empty_s) begin
            cnt_r    <= head_s.len;
            cur_id_r <= head_s.id;
            cur_op_r <= head_s.op;
            cur_wb_r <= head_s.wb;
            cur_vd_r <= head_s.vd;
            rptr_r   <= rptr_r + (AW+1)'(1);
            state_r  <= EXEC;
          end else begin
            state_r  <= IDLE;
          end
        end
        EXEC: begin
          if (cnt_r == '0) begin
            state_r        <= RESULT;
            result_valid_r <= 1'b1;
            result_id_r    <= cur_id_r;
            result_we_r    <= cur_wb_r;
            result_op_r    <= cur_op_r;
          end else begin
            cnt_r <= cnt_r - VLEN_W'(1);
          end
        end
        RESULT: begin
          if (result_ready_i) begin
            result_valid_r <= 1'b0;
            state_r        <= IDLE;
          end else begin
            result_valid_r <= 1'b1;
          end
        end
        default: begin
          state_r        <= IDLE;
          result_valid_r <= 1'b0;
        end
      endcase
    end
  end

  assign result_valid_o = result_valid_r;
  assign result_id_o    = result_id_r;
  assign result_we_o    = result_we_r;
  assign result_op_o    = result_op_r;
  assign busy_o         = !empty_s || (state_r != IDLE);

endmodule
